// File: rtl/riscalar_pkg.sv
// Shared types and constants for the front-end instruction queue.
// Latency: not applicable (types, constants and a pure helper function only).
// Backpressure: not applicable.
package riscalar_pkg;

    localparam int XLEN     = 32;
    localparam int IQ_DEPTH = 8;
    localparam int DROP_W   = 16;

    // One queue slot: the fetched word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } iq_entry_t;

    // Occupancy classes; every one of them is derived from the counter.
    typedef enum logic [1:0] {
        IQ_EMPTY   = 2'd0,
        IQ_PARTIAL = 2'd1,
        IQ_FULL    = 2'd2
    } iq_mode_t;

    // Debug counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch-to-dispatch bundle: push handshake, pop handshake and debug status.
// Latency: wires only.
// Backpressure: iq_ready_out throttles fetch; dispatch_ready_in consumes the head.
interface instruction_queue_if
    import riscalar_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic [XLEN-1:0]   instruction_in;
    logic [XLEN-1:0]   pc_in;
    logic              iq_valid_in;
    logic              iq_ready_out;
    logic [XLEN-1:0]   inst_out;
    logic [XLEN-1:0]   pc_out;
    logic              inst_valid_out;
    logic              dispatch_ready_in;
    logic [CNT_W-1:0]  count_out;
    logic [DROP_W-1:0] drop_cnt_out;

    // Fetch/dispatch side: drives pushes and pop acknowledgements.
    modport master (
        output instruction_in, pc_in, iq_valid_in, dispatch_ready_in,
        input  iq_ready_out, inst_out, pc_out, inst_valid_out, count_out, drop_cnt_out
    );

    // Queue side.
    modport slave (
        input  instruction_in, pc_in, iq_valid_in, dispatch_ready_in,
        output iq_ready_out, inst_out, pc_out, inst_valid_out, count_out, drop_cnt_out
    );
endinterface

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: one write port, one asynchronous read port.
// Latency: a write lands at the clock edge; reads are combinational.
// Backpressure: none; the owner decides when writing is legal.
module iq_storage
    import riscalar_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  iq_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output iq_entry_t        rd_data
);
    // Data needs no reset: slots are only read when the counter says they hold a live entry.
    iq_entry_t mem [DEPTH];

    // Write the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_queue.sv
// Circular instruction queue between fetch and dispatch, in program order, with flush and drop counting.
// Latency: a push at edge N shows at the head in cycle N+1; there is no same-cycle bypass.
// Backpressure: iq_ready_out is low only when full (independent of pop); pushes while full are dropped and counted.
module instruction_queue
    import riscalar_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                flush_in,
    instruction_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [DROP_W-1:0] drop_cnt;
    iq_mode_t          mode;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    iq_entry_t         wr_entry;
    iq_entry_t         head_entry;

    // Occupancy class from the counter alone; pointer equality is never used for full/empty.
    always_comb begin
        mode = IQ_PARTIAL;
        if (count == '0) begin
            mode = IQ_EMPTY;
        end else if (count == CNT_W'(DEPTH)) begin
            mode = IQ_FULL;
        end
    end

    assign full  = (mode == IQ_FULL);
    assign empty = (mode == IQ_EMPTY);

    // Ready ignores dispatch_ready_in, so a full queue refuses a push even in a pop cycle.
    assign push = bus.iq_valid_in && !full;
    assign pop  = !empty && bus.dispatch_ready_in;

    assign wr_entry.inst = bus.instruction_in;
    assign wr_entry.pc   = bus.pc_in;

    iq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk_in),
        .wr_en   (push && !flush_in),
        .wr_addr (tail),
        .wr_data (wr_entry),
        .rd_addr (head),
        .rd_data (head_entry)
    );

    // Pointer and occupancy update; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Dropped-push counter; survives flush and counts a refused push even in a flush cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            drop_cnt <= '0;
        end else if (bus.iq_valid_in && full) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Head data is forced to zero when empty so reset and idle present clean zeros.
    assign bus.inst_out       = empty ? '0 : head_entry.inst;
    assign bus.pc_out         = empty ? '0 : head_entry.pc;
    assign bus.inst_valid_out = !empty;
    assign bus.iq_ready_out   = !full;
    assign bus.count_out      = count;
    assign bus.drop_cnt_out   = drop_cnt;

endmodule
